dmem_arbiter: RTL and testbench

- Two-requester arbiter that shares the single-port data RAM of the pipelined MIPS core.
- Port 0 is the CPU MEM stage. Port 1 is the program/data loader or debug port.
- Drives the RAM's write enable, word address and write data, and returns registered read data to the granted requester.
- Provides round-robin fairness, a lock for uninterrupted bursts, and address checks: out-of-range accesses are rejected, and writes to the RAM's hardwired word 0 are suppressed.

---
 rtl/dmem_arbiter.sv | 96 +++++++++
 tb/tb_dmem_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter with lock and address checks for the shared data RAM.
// Define DMEM_ARB_STATS_EN to add the conflicts/denied counters.
module dmem_arbiter #(
    parameter int DEPTH = 128,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] adr0,
    input  logic [AW-1:0] adr1,
    input  logic [DW-1:0] wd0,
    input  logic [DW-1:0] wd1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rd0,
    output logic [DW-1:0] rd1,
    output logic          err0,
    output logic          err1,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_din,
`ifdef DMEM_ARB_STATS_EN
    output logic [15:0]   conflicts,
    output logic [15:0]   denied,
`endif
    input  logic [DW-1:0] mem_dout
);
    typedef enum logic [1:0] {FREE, HELD0, HELD1} owner_t;
    owner_t owner;
    logic last;
    logic ok0, ok1, bad0, bad1;
    always_comb begin
        gnt0 = !reset && req0 && (owner == HELD0 || (owner == FREE && (!req1 || last)));
        gnt1 = !reset && req1 && (owner == HELD1 || (owner == FREE && (!req0 || !last)));
        ok0 = adr0 < AW'(DEPTH);
        ok1 = adr1 < AW'(DEPTH);
        // word 0 is hardwired in the RAM, so writing it is an error
        bad0 = !ok0 || (we0 && adr0 == '0);
        bad1 = !ok1 || (we1 && adr1 == '0);
        mem_adr = gnt0 ? adr0 : gnt1 ? adr1 : '0;
        mem_din = gnt0 ? wd0 : gnt1 ? wd1 : '0;
        mem_we = (gnt0 && we0 && !bad0) || (gnt1 && we1 && !bad1);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            owner <= FREE;
            last <= 1'b1;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            rd0 <= '0;
            rd1 <= '0;
        end else begin
            rvalid0 <= gnt0 && !we0 && ok0;
            rvalid1 <= gnt1 && !we1 && ok1;
            err0 <= gnt0 && bad0;
            err1 <= gnt1 && bad1;
            if (gnt0 && !we0 && ok0)
                rd0 <= mem_dout;
            if (gnt1 && !we1 && ok1)
                rd1 <= mem_dout;
            if (gnt0) begin
                last <= 1'b0;
                owner <= lock0 ? HELD0 : FREE;
            end else if (gnt1) begin
                last <= 1'b1;
                owner <= lock1 ? HELD1 : FREE;
            end else if ((owner == HELD0 && !lock0) || (owner == HELD1 && !lock1)) begin
                owner <= FREE;
            end
        end
    end
`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            conflicts <= '0;
            denied <= '0;
        end else begin
            if (req0 && req1 && conflicts != 16'hFFFF)
                conflicts <= conflicts + 16'd1;
            if ((req0 && !gnt0) || (req1 && !gnt1))
                denied <= denied + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table, reset corner case, then random traffic vs a reference model.
module tb_dmem_arbiter;
    localparam int DEPTH = 128;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic req[2], we[2], lock[2];
    logic [AW-1:0] adr[2];
    logic [DW-1:0] wd[2];
    logic gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we;
    logic [DW-1:0] rd0, rd1, mem_din, mem_dout;
    logic [AW-1:0] mem_adr;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] conflicts, denied;
`endif

    dmem_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
        .adr0(adr[0]), .adr1(adr[1]), .wd0(wd[0]), .wd1(wd[1]),
        .lock0(lock[0]), .lock1(lock[1]),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rd0(rd0), .rd1(rd1), .err0(err0), .err1(err1),
        .mem_we(mem_we), .mem_adr(mem_adr), .mem_din(mem_din),
`ifdef DMEM_ARB_STATS_EN
        .conflicts(conflicts), .denied(denied),
`endif
        .mem_dout(mem_dout)
    );

    // RAM with asynchronous read and word 0 hardwired to 3
    logic [DW-1:0] ram [DEPTH];
    logic ram_clr;
    always @(posedge clk) begin
        if (ram_clr)
            for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
        else if (mem_we && mem_adr < AW'(DEPTH))
            ram[mem_adr[6:0]] <= mem_din;
    end
    assign mem_dout = (mem_adr == '0) ? 32'd3 : (mem_adr < AW'(DEPTH)) ? ram[mem_adr[6:0]] : '0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int unsigned r0, r1, w0, w1, l0, l1;
        int unsigned a0, a1, d0, d1;
        int unsigned g0, g1, mwe, v0, v1, e0, e1;
        int unsigned rd0, rd1;
    } vec_t;
    vec_t tbl[19];

    // reference model state
    int holder, lst, g, prev_g;
    int unsigned e_conf, e_den;
    logic e_v[2], e_e[2];
    logic [31:0] e_rd[2];
    logic [31:0] ref_mem[DEPTH];
    logic [31:0] ea, ed;
    logic ewe;

    localparam int unsigned DB = 32'hDEADBEEF;

    initial begin
        //           r0 r1 w0 w1 l0 l1  a0   a1  d0   d1           g0 g1 we v0 v1 e0 e1 rd0 rd1
        tbl[0]  = '{1, 0, 1, 0, 0, 0,   5,   0, DB,  0,           1, 0, 1, 0, 0, 0, 0, 0,  0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0,   5,   0, 0,   0,           1, 0, 0, 1, 0, 0, 0, DB, 0};
        tbl[2]  = '{0, 1, 0, 1, 0, 0,   0,   1, 0,   32'h11,      0, 1, 1, 0, 0, 0, 0, DB, 0};
        tbl[3]  = '{0, 1, 0, 1, 0, 0,   0,   2, 0,   32'h22,      0, 1, 1, 0, 0, 0, 0, DB, 0};
        tbl[4]  = '{0, 1, 0, 1, 0, 0,   0,   3, 0,   32'h33,      0, 1, 1, 0, 0, 0, 0, DB, 0};
        tbl[5]  = '{1, 1, 0, 0, 0, 0,   5,   2, 0,   0,           1, 0, 0, 1, 0, 0, 0, DB, 0};
        tbl[6]  = '{1, 1, 0, 0, 0, 0,   5,   2, 0,   0,           0, 1, 0, 0, 1, 0, 0, DB, 32'h22};
        tbl[7]  = '{1, 1, 0, 0, 0, 0,   5,   2, 0,   0,           1, 0, 0, 1, 0, 0, 0, DB, 32'h22};
        tbl[8]  = '{1, 1, 0, 0, 0, 0,   5,   2, 0,   0,           0, 1, 0, 0, 1, 0, 0, DB, 32'h22};
        tbl[9]  = '{1, 1, 0, 0, 0, 1,   5,   1, 0,   0,           1, 0, 0, 1, 0, 0, 0, DB, 32'h22};
        tbl[10] = '{1, 1, 0, 0, 0, 1,   5,   1, 0,   0,           0, 1, 0, 0, 1, 0, 0, DB, 32'h11};
        tbl[11] = '{1, 1, 0, 0, 0, 1,   5,   2, 0,   0,           0, 1, 0, 0, 1, 0, 0, DB, 32'h22};
        tbl[12] = '{1, 1, 0, 0, 0, 0,   5,   3, 0,   0,           0, 1, 0, 0, 1, 0, 0, DB, 32'h33};
        tbl[13] = '{1, 1, 0, 0, 0, 0,   5,   3, 0,   0,           1, 0, 0, 1, 0, 0, 0, DB, 32'h33};
        tbl[14] = '{0, 1, 0, 1, 0, 0,   0,   0, 0,   32'h12345678, 0, 1, 0, 0, 0, 0, 1, DB, 32'h33};
        tbl[15] = '{0, 1, 0, 0, 0, 0,   0,   0, 0,   0,           0, 1, 0, 0, 1, 0, 0, DB, 3};
        tbl[16] = '{1, 0, 0, 0, 0, 0, 128,   0, 0,   0,           1, 0, 0, 0, 0, 1, 0, DB, 3};
        tbl[17] = '{1, 0, 1, 0, 0, 0, 200,   0, 32'hAA, 0,        1, 0, 0, 0, 0, 1, 0, DB, 3};
        tbl[18] = '{0, 0, 0, 0, 0, 0,   0,   0, 0,   0,           0, 0, 0, 0, 0, 0, 0, DB, 3};

        // reset: requests present during reset must be ignored
        reset = 1'b1;
        ram_clr = 1'b1;
        for (int n = 0; n < 2; n++) begin
            req[n] = 1'b1; we[n] = 1'b1; lock[n] = 1'b0; adr[n] = 32'd7; wd[n] = 32'h55;
        end
        @(negedge clk);
        chk("reset_gnt0", 32'(gnt0), 0);
        chk("reset_gnt1", 32'(gnt1), 0);
        chk("reset_mem_we", 32'(mem_we), 0);
        @(posedge clk); #1;
        ram_clr = 1'b0;
        chk("reset_rvalid0", 32'(rvalid0), 0);
        chk("reset_rvalid1", 32'(rvalid1), 0);
        chk("reset_err0", 32'(err0), 0);
        chk("reset_err1", 32'(err1), 0);
        chk("reset_rd0", rd0, 0);
        chk("reset_rd1", rd1, 0);
`ifdef DMEM_ARB_STATS_EN
        chk("reset_conflicts", 32'(conflicts), 0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            req[0] = tbl[i].r0[0]; req[1] = tbl[i].r1[0];
            we[0] = tbl[i].w0[0]; we[1] = tbl[i].w1[0];
            lock[0] = tbl[i].l0[0]; lock[1] = tbl[i].l1[0];
            adr[0] = tbl[i].a0; adr[1] = tbl[i].a1;
            wd[0] = tbl[i].d0; wd[1] = tbl[i].d1;
            @(negedge clk);
            chk($sformatf("v%0d_gnt0", i), 32'(gnt0), tbl[i].g0);
            chk($sformatf("v%0d_gnt1", i), 32'(gnt1), tbl[i].g1);
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), tbl[i].mwe);
            @(posedge clk); #1;
            chk($sformatf("v%0d_rvalid0", i), 32'(rvalid0), tbl[i].v0);
            chk($sformatf("v%0d_rvalid1", i), 32'(rvalid1), tbl[i].v1);
            chk($sformatf("v%0d_err0", i), 32'(err0), tbl[i].e0);
            chk($sformatf("v%0d_err1", i), 32'(err1), tbl[i].e1);
            chk($sformatf("v%0d_rd0", i), rd0, tbl[i].rd0);
            chk($sformatf("v%0d_rd1", i), rd1, tbl[i].rd1);
        end

        // reset while port 1 holds the lock
        req[0] = 1'b1; req[1] = 1'b1; we[0] = 1'b0; we[1] = 1'b0;
        adr[0] = 32'd5; adr[1] = 32'd3; lock[0] = 1'b0; lock[1] = 1'b1;
        @(negedge clk);
        chk("rs_hold_gnt1", 32'(gnt1), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rs_gnt0", 32'(gnt0), 0);
        chk("rs_gnt1", 32'(gnt1), 0);
        chk("rs_mem_we", 32'(mem_we), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rs_rvalid0", 32'(rvalid0), 0);
        chk("rs_rvalid1", 32'(rvalid1), 0);
        chk("rs_rd1", rd1, 0);
`ifdef DMEM_ARB_STATS_EN
        chk("rs_conflicts", 32'(conflicts), 0);
`endif
        @(negedge clk);
        chk("rs_after_gnt0", 32'(gnt0), 1);
        chk("rs_after_gnt1", 32'(gnt1), 0);
        @(posedge clk); #1;
        chk("rs_after_rvalid0", 32'(rvalid0), 1);
        chk("rs_after_rd0", rd0, DB);

        // random traffic against the reference model, from a clean RAM
        reset = 1'b1;
        ram_clr = 1'b1;
        for (int n = 0; n < 2; n++) begin
            req[n] = 1'b0; lock[n] = 1'b0;
        end
        @(posedge clk); #1;
        ram_clr = 1'b0;
        reset = 1'b0;
        holder = -1; lst = 1; prev_g = -1; e_conf = 0; e_den = 0;
        for (int n = 0; n < 2; n++) begin
            e_v[n] = 1'b0; e_e[n] = 1'b0; e_rd[n] = '0;
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_mem[0] = 32'd3;

        for (int c = 0; c < 500; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!req[n] || prev_g == n || $urandom_range(0, 9) == 0) begin
                    req[n] = $urandom_range(0, 3) != 0;
                    we[n] = $urandom_range(0, 1) == 1;
                    adr[n] = ($urandom_range(0, 7) == 0) ? $urandom_range(128, 300) : $urandom_range(0, 15);
                    wd[n] = $urandom;
                end
                lock[n] = $urandom_range(0, 3) == 0;
            end
            reset = $urandom_range(0, 99) == 0;
            @(negedge clk);
            g = -1;
            if (!reset) begin
                if (holder >= 0) g = req[holder] ? holder : -1;
                else if (req[0] && req[1]) g = 1 - lst;
                else if (req[0]) g = 0;
                else if (req[1]) g = 1;
            end
            ea = '0; ed = '0; ewe = 1'b0;
            if (g >= 0) begin
                ea = adr[g]; ed = wd[g];
                ewe = we[g] && adr[g] < DEPTH && adr[g] != 0;
            end
            chk("rnd_gnt0", 32'(gnt0), 32'(g == 0));
            chk("rnd_gnt1", 32'(gnt1), 32'(g == 1));
            chk("rnd_mem_we", 32'(mem_we), 32'(ewe));
            chk("rnd_mem_adr", mem_adr, ea);
            chk("rnd_mem_din", mem_din, ed);
            if (reset) begin
                e_conf = 0; e_den = 0; holder = -1; lst = 1;
                for (int n = 0; n < 2; n++) begin
                    e_v[n] = 1'b0; e_e[n] = 1'b0; e_rd[n] = '0;
                end
            end else begin
                if (req[0] && req[1] && e_conf < 65535) e_conf++;
                if ((req[0] && g != 0) || (req[1] && g != 1)) e_den = (e_den + 1) % 65536;
                for (int n = 0; n < 2; n++) begin
                    e_v[n] = 1'b0; e_e[n] = 1'b0;
                end
                if (g >= 0) begin
                    if (adr[g] >= DEPTH || (we[g] && adr[g] == 0)) e_e[g] = 1'b1;
                    else if (we[g]) ref_mem[adr[g]] = wd[g];
                    else begin
                        e_v[g] = 1'b1;
                        e_rd[g] = ref_mem[adr[g]];
                    end
                    lst = g;
                    holder = lock[g] ? g : -1;
                end else if (holder >= 0 && !lock[holder]) begin
                    holder = -1;
                end
            end
            @(posedge clk); #1;
            chk("rnd_rvalid0", 32'(rvalid0), 32'(e_v[0]));
            chk("rnd_rvalid1", 32'(rvalid1), 32'(e_v[1]));
            chk("rnd_err0", 32'(err0), 32'(e_e[0]));
            chk("rnd_err1", 32'(err1), 32'(e_e[1]));
            chk("rnd_rd0", rd0, e_rd[0]);
            chk("rnd_rd1", rd1, e_rd[1]);
`ifdef DMEM_ARB_STATS_EN
            chk("rnd_conflicts", 32'(conflicts), e_conf);
            chk("rnd_denied", 32'(denied), e_den);
`endif
            prev_g = g;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
